checkpoint_restore_ctrl: RTL and testbench

Sequencer between hazard control, register_snapshot and the register file write port.
- On a predicted branch it requests a register checkpoint and waits for the snapshot to complete.
- When the branch resolves correctly it releases the checkpoint.
- On a misprediction it writes the checkpointed values back into the register file one register per cycle and stalls the pipeline until the restore finishes.

---
 rtl/mips_core_pkg.sv | 21 ++
 rtl/restore_index_counter.sv | 45 ++++
 rtl/checkpoint_restore_ctrl.sv | 153 +++++++++++++++
 tb/tb_checkpoint_restore_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_core_pkg
// Description : Shared types and constants for the checkpoint/restore path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    // Checkpoint sequencer states, two bits wide.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SNAP    = 2'd1,
        SPEC    = 2'd2,
        RESTORE = 2'd3
    } ckpt_state_t;

    // Hard-wired zero register; never restored.
    localparam int REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/restore_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : restore_index_counter
// Description : Register index walker for the restore sequence. Starts at the
//               first non-zero register, advances on enable, flags the last
//               architectural register and returns to the start after it.
// Revision    : 1.0 - initial release
// ============================================================================
module restore_index_counter
    import mips_core_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] C_FIRST_IDX = ADDR_WIDTH'(REG_ZERO + 1);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  w_last;

    assign w_last = (r_idx == C_LAST_IDX);
    assign idx    = r_idx;
    assign last   = w_last;

    // Index register: wraps back to the first restorable register, never past the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= C_FIRST_IDX;
        end else if (clear || (enable && w_last)) begin
            r_idx <= C_FIRST_IDX;
        end else if (enable) begin
            r_idx <= r_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/checkpoint_restore_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : checkpoint_restore_ctrl
// Description : Sequencer between hazard control, register_snapshot and the
//               register file write port. Takes a checkpoint on a predicted
//               branch, releases it on a correct resolve, and replays the
//               checkpoint into the register file on a mispredict while
//               stalling the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module checkpoint_restore_ctrl
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 branch_predict,
    input  logic                                 branch_resolve_valid,
    input  logic                                 branch_mispredict,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  snap_regs,
    input  logic                                 snap_done,
    output logic                                 take_snapshot,
    output logic                                 rf_wr_en,
    output logic [ADDR_WIDTH-1:0]                rf_wr_addr,
    output logic [DATA_WIDTH-1:0]                rf_wr_data,
    output logic                                 restore_stall,
    output logic                                 restore_done,
    output logic                                 ckpt_busy
);

    ckpt_state_t           r_state;
    ckpt_state_t           w_state_nxt;
    logic                  r_pend_valid;
    logic                  r_pend_mis;
    logic                  w_pend_valid_nxt;
    logic                  w_pend_mis_nxt;
    logic                  w_res_valid;
    logic                  w_res_mis;
    logic                  w_idx_clear;
    logic                  w_idx_en;
    logic                  w_idx_last;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_writing;

    restore_index_counter #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_idx_clear),
        .enable (w_idx_en),
        .idx    (w_idx),
        .last   (w_idx_last)
    );

    // State and pending-resolve registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pend_valid <= 1'b0;
            r_pend_mis   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_mis   <= w_pend_mis_nxt;
        end
    end

    // Next-state, index control and output decode (outputs depend on state/idx only).
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_mis_nxt   = r_pend_mis;
        w_idx_clear      = 1'b0;
        w_idx_en         = 1'b0;
        // A resolve seen on the exit edge counts as well as one latched earlier.
        w_res_valid      = r_pend_valid | branch_resolve_valid;
        w_res_mis        = r_pend_valid ? r_pend_mis : branch_mispredict;

        case (r_state)
            IDLE: begin
                w_pend_valid_nxt = 1'b0;
                w_pend_mis_nxt   = 1'b0;
                if (branch_predict) begin
                    w_state_nxt = SNAP;
                end
            end
            SNAP: begin
                if (snap_done) begin
                    w_pend_valid_nxt = 1'b0;
                    w_pend_mis_nxt   = 1'b0;
                    if (!w_res_valid) begin
                        w_state_nxt = SPEC;
                    end else if (w_res_mis) begin
                        w_state_nxt = RESTORE;
                        w_idx_clear = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (branch_resolve_valid && !r_pend_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_mis_nxt   = branch_mispredict;
                end
            end
            SPEC: begin
                if (branch_resolve_valid) begin
                    if (branch_mispredict) begin
                        // Wrong path is squashed, so a same-cycle predict is dropped.
                        w_state_nxt = RESTORE;
                        w_idx_clear = 1'b1;
                    end else if (branch_predict) begin
                        w_state_nxt = SNAP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            RESTORE: begin
                w_idx_en = 1'b1;
                if (w_idx_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_writing     = (r_state == RESTORE) && (w_idx != ADDR_WIDTH'(REG_ZERO));
        take_snapshot = (r_state == SNAP);
        ckpt_busy     = (r_state != IDLE);
        restore_stall = (r_state == RESTORE);
        rf_wr_en      = w_writing;
        rf_wr_addr    = w_writing ? w_idx : '0;
        rf_wr_data    = w_writing ? snap_regs[w_idx] : '0;
        restore_done  = w_writing && w_idx_last;
    end

`ifndef SYNTHESIS
    // Hazard control must not predict while a checkpoint is held unless the
    // held branch resolves in the same cycle.
    a_no_predict_in_spec: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == SPEC && branch_predict) |-> branch_resolve_valid
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_restore_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_checkpoint_restore_ctrl
// Description : Self-checking bench: directed vector table, hand-written
//               restore/reset sequences and a randomized run against a
//               behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_checkpoint_restore_ctrl;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   branch_predict = 1'b0;
    logic                   branch_resolve_valid = 1'b0;
    logic                   branch_mispredict = 1'b0;
    logic [NR-1:0][DW-1:0]  snap_regs;
    logic                   snap_done = 1'b0;
    logic                   take_snapshot;
    logic                   rf_wr_en;
    logic [AW-1:0]          rf_wr_addr;
    logic [DW-1:0]          rf_wr_data;
    logic                   restore_stall;
    logic                   restore_done;
    logic                   ckpt_busy;

    int tests = 0;
    int fails = 0;

    checkpoint_restore_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .branch_predict       (branch_predict),
        .branch_resolve_valid (branch_resolve_valid),
        .branch_mispredict    (branch_mispredict),
        .snap_regs            (snap_regs),
        .snap_done            (snap_done),
        .take_snapshot        (take_snapshot),
        .rf_wr_en             (rf_wr_en),
        .rf_wr_addr           (rf_wr_addr),
        .rf_wr_data           (rf_wr_data),
        .restore_stall        (restore_stall),
        .restore_done         (restore_done),
        .ckpt_busy            (ckpt_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bp, rv, rm, sd;
        logic       e_take, e_busy, e_stall, e_wr, e_done;
        logic [4:0] e_addr;
    } vec_t;

    vec_t tbl[16];

    // Behavioural model: what the controller is doing, in plain terms.
    bit m_snapping, m_held, m_pv, m_pm;
    int m_rpos; // next register to restore, 0 when not restoring

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic bp, input logic rv, input logic rm, input logic sd);
        @(negedge clk);
        branch_predict       = bp;
        branch_resolve_valid = rv;
        branch_mispredict    = rm;
        snap_done            = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        branch_predict = 0; branch_resolve_valid = 0; branch_mispredict = 0; snap_done = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_snapping = 0; m_held = 0; m_pv = 0; m_pm = 0; m_rpos = 0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < NR; i++) snap_regs[i] = 32'hA000_0000 + i;
    endtask

    task automatic model_step(input bit bp, input bit rv, input bit rm, input bit sd);
        bit ev, em;
        if (m_rpos != 0) begin
            m_rpos = (m_rpos == NR - 1) ? 0 : m_rpos + 1;
        end else if (m_snapping) begin
            ev = m_pv | rv;
            em = m_pv ? m_pm : rm;
            if (sd) begin
                m_snapping = 0; m_pv = 0; m_pm = 0;
                if (!ev) m_held = 1;
                else if (em) m_rpos = 1;
            end else if (rv && !m_pv) begin
                m_pv = 1; m_pm = rm;
            end
        end else if (m_held) begin
            if (rv) begin
                m_held = 0;
                if (rm) m_rpos = 1;
                else if (bp) m_snapping = 1;
            end
        end else if (bp) begin
            m_snapping = 1;
        end
    endtask

    initial begin
        int cnt;
        bit bp, rv, rm, sd;
        logic [4:0] exp_ctrl;

        fill_pattern();

        //                 bp rv rm sd  take busy stall wr done addr
        tbl[0]  = '{1, 0, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[1]  = '{0, 0, 0, 1,  0, 1, 0, 0, 0, 5'd0};
        tbl[2]  = '{0, 0, 0, 0,  0, 1, 0, 0, 0, 5'd0};
        tbl[3]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 5'd0};
        tbl[4]  = '{0, 1, 1, 0,  0, 0, 0, 0, 0, 5'd0};
        tbl[5]  = '{1, 0, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[6]  = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[7]  = '{0, 0, 0, 1,  0, 1, 0, 0, 0, 5'd0};
        tbl[8]  = '{1, 1, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[9]  = '{0, 0, 0, 1,  0, 1, 0, 0, 0, 5'd0};
        tbl[10] = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 5'd0};
        tbl[11] = '{1, 0, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[12] = '{0, 1, 1, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[13] = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 5'd0};
        tbl[14] = '{0, 0, 0, 1,  0, 1, 1, 1, 0, 5'd1};
        tbl[15] = '{1, 1, 0, 0,  0, 1, 1, 1, 0, 5'd2};

        // Reset state
        #2;
        chk("reset_outputs", {59'd0, take_snapshot, ckpt_busy, restore_stall, rf_wr_en, restore_done}, 64'd0);
        do_reset();
        #1;
        chk("reset_release", {take_snapshot, ckpt_busy, restore_stall, rf_wr_en, restore_done, rf_wr_addr}, 64'd0);

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].bp, tbl[v].rv, tbl[v].rm, tbl[v].sd);
            chk($sformatf("vec%0d", v),
                {take_snapshot, ckpt_busy, restore_stall, rf_wr_en, restore_done, rf_wr_addr},
                {tbl[v].e_take, tbl[v].e_busy, tbl[v].e_stall, tbl[v].e_wr, tbl[v].e_done, tbl[v].e_addr});
        end

        // Full mispredict restore: 31 writes, addr 1..31, done on the last
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 1, 1, 0);
        cnt = 0;
        while (rf_wr_en && cnt < 40) begin
            cnt++;
            chk("restore_addr", rf_wr_addr, cnt);
            chk("restore_data", rf_wr_data, 32'hA000_0000 + cnt);
            chk("restore_done", restore_done, (cnt == NR - 1));
            chk("restore_stall", restore_stall, 1);
            drive(0, 0, 0, 0);
        end
        chk("restore_len", cnt, NR - 1);
        chk("restore_after", {take_snapshot, ckpt_busy, restore_stall, rf_wr_en, restore_done}, 0);

        // Reset asserted mid-restore at addr 10
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 1, 1, 0);
        cnt = 0;
        while (rf_wr_addr != 5'd10 && cnt < 40) begin
            cnt++;
            drive(0, 0, 0, 0);
        end
        chk("midrst_reach10", {rf_wr_en, rf_wr_addr}, {1'b1, 5'd10});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_immediate", {rf_wr_en, restore_stall, ckpt_busy, take_snapshot, restore_done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 0);
            if (rf_wr_en || ckpt_busy || restore_stall || take_snapshot || restore_done) cnt++;
        end
        chk("midrst_quiet", cnt, 0);

        // Randomized run against the behavioural model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_ctrl = {m_snapping, (m_snapping | m_held | (m_rpos != 0)), (m_rpos != 0),
                        (m_rpos != 0), (m_rpos == NR - 1)};
            chk("rnd_ctrl", {take_snapshot, ckpt_busy, restore_stall, rf_wr_en, restore_done}, exp_ctrl);
            chk("rnd_addr", rf_wr_addr, (m_rpos != 0) ? m_rpos : 0);
            chk("rnd_data", rf_wr_data, (m_rpos != 0) ? snap_regs[m_rpos] : 0);
            for (int j = 0; j < NR; j++) snap_regs[j] = $urandom;
            bp = ($urandom % 4) == 0;
            rv = ($urandom % 5) == 0;
            rm = ($urandom % 2) == 0;
            sd = ($urandom % 3) == 0;
            if (m_held && !m_snapping && m_rpos == 0 && !rv) bp = 0;
            branch_predict       = bp;
            branch_resolve_valid = rv;
            branch_mispredict    = rm;
            snap_done            = sd;
            model_step(bp, rv, rm, sd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
